// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// Decides PC / pipeline-register write enables and bubble insertion for
// load-use hazards, taken branches, memory freezes and the HLT drain
// sequence, and keeps a saturating count of stall cycles.
module hazard_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [3:0]       id_src1,
   input  logic [3:0]       id_src2,
   input  logic             id_uses_src1,
   input  logic             id_uses_src2,
   input  logic             id_halt,
   input  logic             dx_MemRead,
   input  logic             dx_RegWrite,
   input  logic [3:0]       dx_reg_dest,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pc_wen,
   output logic             fd_wen,
   output logic             dx_wen,
   output logic             xm_wen,
   output logic             fd_flush,
   output logic             dx_flush,
   output logic             halt_done,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   // Drain counter starts one below the bubble count because the cycle
   // that sees dcnt==0 is itself the last drain cycle.
   localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [1:0] dcnt;
   logic [1:0] dcnt_next;

   logic src1_match;
   logic src2_match;
   logic hz;
   logic halt_req;
   logic stall_inc;

   // Load-use hazard: the instruction in execute is a load to a real
   // register that the decode instruction is about to read.
   always_comb begin
      src1_match = id_uses_src1 && (id_src1 == dx_reg_dest);
      src2_match = id_uses_src2 && (id_src2 == dx_reg_dest);
      hz         = id_valid && dx_MemRead && dx_RegWrite &&
                   (dx_reg_dest != 4'd0) && (src1_match || src2_match);
      halt_req   = id_valid && id_halt;
   end

   // State and drain counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         dcnt  <= 2'd0;
      end else begin
         state <= state_next;
         dcnt  <= dcnt_next;
      end
   end

   // Next-state and output decode; priority is memory freeze, then taken
   // branch, then halt/hazard, then normal flow. Reset forces every
   // output low without waiting for a clock edge.
   always_comb begin
      state_next = state;
      dcnt_next  = dcnt;
      pc_wen     = 1'b0;
      fd_wen     = 1'b0;
      dx_wen     = 1'b0;
      xm_wen     = 1'b0;
      fd_flush   = 1'b0;
      dx_flush   = 1'b0;
      halt_done  = 1'b0;

      if (!rst) begin
         state_next = RUN;
         dcnt_next  = 2'd0;
      end else begin
         case (state)
            RUN: begin
               if (mem_busy) begin
                  state_next = RUN;
               end else if (ex_branch_taken) begin
                  pc_wen   = 1'b1;
                  fd_wen   = 1'b1;
                  dx_wen   = 1'b1;
                  xm_wen   = 1'b1;
                  fd_flush = 1'b1;
                  dx_flush = 1'b1;
               end else if (hz) begin
                  dx_wen   = 1'b1;
                  dx_flush = 1'b1;
                  xm_wen   = 1'b1;
               end else if (halt_req) begin
                  dx_wen     = 1'b1;
                  xm_wen     = 1'b1;
                  state_next = DRAIN;
                  dcnt_next  = DRAIN_INIT;
               end else begin
                  pc_wen = 1'b1;
                  fd_wen = 1'b1;
                  dx_wen = 1'b1;
                  xm_wen = 1'b1;
               end
            end

            DRAIN: begin
               if (mem_busy) begin
                  state_next = DRAIN;
               end else if (ex_branch_taken) begin
                  pc_wen     = 1'b1;
                  fd_wen     = 1'b1;
                  dx_wen     = 1'b1;
                  xm_wen     = 1'b1;
                  fd_flush   = 1'b1;
                  dx_flush   = 1'b1;
                  state_next = RUN;
                  dcnt_next  = 2'd0;
               end else begin
                  fd_flush = 1'b1;
                  dx_wen   = 1'b1;
                  dx_flush = 1'b1;
                  xm_wen   = 1'b1;
                  if (dcnt == 2'd0) begin
                     state_next = HALTED;
                  end else begin
                     dcnt_next = dcnt - 2'd1;
                  end
               end
            end

            HALTED: begin
               halt_done = 1'b1;
            end

            default: begin
               state_next = RUN;
               dcnt_next  = 2'd0;
            end
         endcase
      end
   end

   // A cycle counts as a stall when the pipe is frozen by memory or a
   // load-use bubble is actually inserted (a taken branch overrides it).
   always_comb begin
      stall_inc = (state != HALTED) &&
                  (mem_busy || (hz && !ex_branch_taken));
   end

   // Saturating stall performance counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural pipeline model.
module tb_hazard_ctrl;

   localparam int DRAIN_CYCLES = 3;
   localparam int CNT_W        = 16;
   localparam int CNT_MAX      = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             id_valid;
   logic [3:0]       id_src1;
   logic [3:0]       id_src2;
   logic             id_uses_src1;
   logic             id_uses_src2;
   logic             id_halt;
   logic             dx_MemRead;
   logic             dx_RegWrite;
   logic [3:0]       dx_reg_dest;
   logic             ex_branch_taken;
   logic             mem_busy;
   logic             pc_wen;
   logic             fd_wen;
   logic             dx_wen;
   logic             xm_wen;
   logic             fd_flush;
   logic             dx_flush;
   logic             halt_done;
   logic [CNT_W-1:0] stall_cnt;

   hazard_ctrl #(
      .DRAIN_CYCLES(DRAIN_CYCLES),
      .CNT_W       (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .id_valid       (id_valid),
      .id_src1        (id_src1),
      .id_src2        (id_src2),
      .id_uses_src1   (id_uses_src1),
      .id_uses_src2   (id_uses_src2),
      .id_halt        (id_halt),
      .dx_MemRead     (dx_MemRead),
      .dx_RegWrite    (dx_RegWrite),
      .dx_reg_dest    (dx_reg_dest),
      .ex_branch_taken(ex_branch_taken),
      .mem_busy       (mem_busy),
      .pc_wen         (pc_wen),
      .fd_wen         (fd_wen),
      .dx_wen         (dx_wen),
      .xm_wen         (xm_wen),
      .fd_flush       (fd_flush),
      .dx_flush       (dx_flush),
      .halt_done      (halt_done),
      .stall_cnt      (stall_cnt)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: halted flag, bubbles still owed to the drain,
   // and the stall count as a plain integer.
   bit mHalted    = 1'b0;
   int mDrainLeft = 0;
   int mCnt       = 0;
   int haltedFor  = 0;

   task automatic checkOne(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic bit modelHz();
      bit m1;
      bit m2;
      m1 = id_uses_src1 && (id_src1 == dx_reg_dest);
      m2 = id_uses_src2 && (id_src2 == dx_reg_dest);
      return id_valid && dx_MemRead && dx_RegWrite && (dx_reg_dest != 0) && (m1 || m2);
   endfunction

   task automatic applyStimulus(input bit valid, input int s1, input int s2,
                                input bit u1, input bit u2, input bit halt,
                                input bit mr, input bit rw, input int dest,
                                input bit br, input bit busy);
      id_valid        = valid;
      id_src1         = 4'(s1);
      id_src2         = 4'(s2);
      id_uses_src1    = u1;
      id_uses_src2    = u2;
      id_halt         = halt;
      dx_MemRead      = mr;
      dx_RegWrite     = rw;
      dx_reg_dest     = 4'(dest);
      ex_branch_taken = br;
      mem_busy        = busy;
   endtask

   task automatic applyIdle();
      applyStimulus(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic checkOutput(input string tag);
      bit ePc;
      bit eFd;
      bit eDx;
      bit eXm;
      bit eFf;
      bit eDf;
      {ePc, eFd, eDx, eXm, eFf, eDf} = 6'b000000;
      #1;
      if (!rst || mHalted || mem_busy) begin
         {ePc, eFd, eDx, eXm, eFf, eDf} = 6'b000000;
      end else if (ex_branch_taken) begin
         {ePc, eFd, eDx, eXm, eFf, eDf} = 6'b111111;
      end else if (mDrainLeft > 0) begin
         {ePc, eFd, eDx, eXm, eFf, eDf} = 6'b001111;
      end else if (modelHz()) begin
         {ePc, eFd, eDx, eXm, eFf, eDf} = 6'b001101;
      end else if (id_valid && id_halt) begin
         {ePc, eFd, eDx, eXm, eFf, eDf} = 6'b001100;
      end else begin
         {ePc, eFd, eDx, eXm, eFf, eDf} = 6'b111100;
      end
      checkOne({tag, ".pc_wen"},    32'(pc_wen),    32'(ePc));
      checkOne({tag, ".fd_wen"},    32'(fd_wen),    32'(eFd));
      checkOne({tag, ".dx_wen"},    32'(dx_wen),    32'(eDx));
      checkOne({tag, ".xm_wen"},    32'(xm_wen),    32'(eXm));
      checkOne({tag, ".fd_flush"},  32'(fd_flush),  32'(eFf));
      checkOne({tag, ".dx_flush"},  32'(dx_flush),  32'(eDf));
      checkOne({tag, ".halt_done"}, 32'(halt_done), 32'(rst && mHalted));
      checkOne({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(mCnt));
   endtask

   // Advance the model across one rising edge using the held inputs.
   task automatic modelUpdate();
      bit hz;
      hz = modelHz();
      if (!rst || mHalted) return;
      if (mem_busy || (hz && !ex_branch_taken)) begin
         if (mCnt < CNT_MAX) mCnt++;
      end
      if (mem_busy) begin
         return;
      end else if (ex_branch_taken) begin
         mDrainLeft = 0;
      end else if (mDrainLeft > 0) begin
         mDrainLeft--;
         if (mDrainLeft == 0) mHalted = 1'b1;
      end else if (!hz && id_valid && id_halt) begin
         mDrainLeft = DRAIN_CYCLES;
      end
   endtask

   // One checked clock cycle; entered and left just after a falling edge.
   task automatic cycle(input string tag);
      checkOutput(tag);
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
   endtask

   // Asynchronous reset pulse asserted mid-cycle, released at a falling edge.
   task automatic doReset(input string tag);
      #2;
      rst        = 1'b0;
      mHalted    = 1'b0;
      mDrainLeft = 0;
      mCnt       = 0;
      haltedFor  = 0;
      checkOutput({tag, ".async"});
      @(posedge clk);
      checkOutput({tag, ".held"});
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Hold memory busy for many cycles without per-cycle comparison.
   task automatic runBusy(input int n);
      applyStimulus(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         modelUpdate();
      end
      @(negedge clk);
   endtask

   // Directed scenarios first, then randomized traffic with periodic resets.
   initial begin
      applyIdle();
      #2;
      checkOutput("reset");
      @(negedge clk);
      rst = 1'b1;
      cycle("run_first");

      // load-use hazard on src2
      applyStimulus(1, 0, 5, 0, 1, 0, 1, 1, 5, 0, 0);
      cycle("hz_src2");
      applyIdle();
      cycle("after_hz");
      // same with destination r0: no hazard
      applyStimulus(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
      cycle("hz_r0");
      // matching src1 not used: no hazard
      applyStimulus(1, 7, 3, 0, 1, 0, 1, 1, 7, 0, 0);
      cycle("hz_unused");
      // hazard and branch together: branch wins
      applyStimulus(1, 6, 0, 1, 0, 0, 1, 1, 6, 1, 0);
      cycle("hz_branch");
      // halt with hazard: hazard first, halt on the following cycle
      applyStimulus(1, 9, 0, 1, 0, 1, 1, 1, 9, 0, 0);
      cycle("halt_hz");
      applyStimulus(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      cycle("halt_accept");
      applyIdle();
      for (int i = 0; i < DRAIN_CYCLES; i++) cycle("drain");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1, $urandom_range(0, 15), 0, 1, 1, 1, 1, 1,
                       $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1));
         cycle("halted");
      end

      // branch on the second drain cycle returns to RUN
      doReset("rst_a");
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      cycle("halt_b");
      applyIdle();
      cycle("drain_b1");
      applyStimulus(1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 0);
      cycle("drain_branch");
      applyIdle();
      for (int i = 0; i < 4; i++) cycle("run_after_branch");

      // memory freeze during drain delays completion
      doReset("rst_b");
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      cycle("halt_c");
      applyIdle();
      cycle("drain_c1");
      applyStimulus(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cycle("drain_busy");
      applyIdle();
      for (int i = 0; i < DRAIN_CYCLES + 1; i++) cycle("drain_c_end");

      // counter saturation, then reset in the middle of a drain
      doReset("rst_c");
      runBusy(CNT_MAX + 3);
      checkOutput("sat");
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      cycle("halt_sat");
      applyIdle();
      cycle("drain_sat");
      doReset("rst_mid_drain");
      applyIdle();
      cycle("run_after_rst");
      cycle("run_after_rst2");

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         if ((mHalted && haltedFor > 3) || $urandom_range(0, 199) == 0) begin
            doReset("rand_rst");
         end else begin
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3), $urandom_range(0, 7) == 0,
                          $urandom_range(0, 5) == 0);
            if (mHalted) haltedFor++;
            cycle("rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
